// File: rtl/uart_byte_rx_pkg.sv
// Shared definitions for the UART byte receiver and its matching transmitter.
// State encodings, default line settings and baud divider derivation.
package uart_byte_rx_pkg;

  localparam int unsigned DEF_CLK_FREQ = 50000000;
  localparam int unsigned DEF_BAUD     = 115200;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rx_state_e;

  function automatic int unsigned baud_div(
    input int unsigned clk_freq,
    input int unsigned baud
  );
    return clk_freq / baud;
  endfunction

  function automatic int unsigned half_div(
    input int unsigned clk_freq,
    input int unsigned baud
  );
    return baud_div(clk_freq, baud) / 2;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer for an asynchronous input.
// Both flops reset to RST_VAL.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: one rx_done strobe per good frame.
// Framing errors strobe rx_frame_err and wait for the line to go high.
module uart_byte_rx
  import uart_byte_rx_pkg::*;
#(
  parameter int unsigned CLK_FREQ = DEF_CLK_FREQ,
  parameter int unsigned BAUD     = DEF_BAUD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rxd,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int unsigned BAUD_DIV = baud_div(CLK_FREQ, BAUD);
  localparam int unsigned HALF     = half_div(CLK_FREQ, BAUD);
  localparam int unsigned CW       = $clog2(BAUD_DIV);

  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(HALF - 1);

  rx_state_e     state_q;
  rx_state_e     state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [2:0]    bit_q;
  logic [2:0]    bit_d;
  logic [7:0]    shift_q;
  logic [7:0]    shift_d;
  logic [7:0]    data_q;
  logic [7:0]    data_d;
  logic          done_q;
  logic          done_d;
  logic          ferr_q;
  logic          ferr_d;
  logic          rxd_s;
  logic          rxd_dly_q;
  logic          cnt_wrap;

  sync_2ff #(
    .RST_VAL (1'b0)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (uart_rxd),
    .q     (rxd_s)
  );

  assign cnt_wrap = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rxd_dly_q && !rxd_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == CNT_MID) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          state_d = rxd_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_wrap) begin
          cnt_d   = '0;
          shift_d = {rxd_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        // Leave mid-stop-bit so a back-to-back start edge is not missed.
        if (cnt_wrap) begin
          cnt_d = '0;
          if (rxd_s) begin
            data_d  = shift_q;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (rxd_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= 3'd0;
      shift_q   <= 8'd0;
      data_q    <= 8'd0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
      rxd_dly_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
      rxd_dly_q <= rxd_s;
    end
  end

  assign rx_data      = data_q;
  assign rx_done      = done_q;
  assign rx_frame_err = ferr_q;
  assign rx_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_byte_rx.sv
// Randomized bench for uart_byte_rx against a frame-level event model.
// Small divider instance for most tests, one default-rate frame at the end.
module tb_uart_byte_rx;
  import uart_byte_rx_pkg::*;

  localparam int CLKF  = 1000000;
  localparam int BAUDR = 100000;
  localparam int BD    = CLKF / BAUDR;
  localparam int HF    = BD / 2;
  localparam int LAT   = 2 + HF + 9 * BD + 1;

  localparam int BD_B  = DEF_CLK_FREQ / DEF_BAUD;
  localparam int HF_B  = BD_B / 2;
  localparam int LAT_B = 2 + HF_B + 9 * BD_B + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic       rxd_b = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_ferr;
  logic       rx_busy;
  logic [7:0] rx_data_b;
  logic       done_b;
  logic       ferr_b;
  logic       busy_b;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_byte_rx #(
    .CLK_FREQ (CLKF),
    .BAUD     (BAUDR)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .uart_rxd     (rxd),
    .rx_data      (rx_data),
    .rx_done      (rx_done),
    .rx_frame_err (rx_ferr),
    .rx_busy      (rx_busy)
  );

  uart_byte_rx dut_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .uart_rxd     (rxd_b),
    .rx_data      (rx_data_b),
    .rx_done      (done_b),
    .rx_frame_err (ferr_b),
    .rx_busy      (busy_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d",
               tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    bit         err;
    int         at;
    logic [7:0] data;
  } ev_t;

  ev_t        expq[$];
  ev_t        ev;
  logic [7:0] last_good = 8'd0;

  // Every strobe must match the next expected frame outcome in order.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_done && rx_ferr)
        check("done_and_err", 32'd1, 32'd0);
      if (rx_done || rx_ferr) begin
        if (expq.size() == 0) begin
          check(rx_done ? "spurious_done" : "spurious_err", 32'd1, 32'd0);
        end else begin
          ev = expq.pop_front();
          check("ev_kind", 32'(rx_ferr), 32'(ev.err));
          check("ev_cycle", cyc, ev.at);
          if (!ev.err) last_good = ev.data;
          check("ev_data", 32'(rx_data), 32'(last_good));
        end
      end else if (cyc % 32 == 0) begin
        check("data_hold", 32'(rx_data), 32'(last_good));
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) step();
  endtask

  // Drives start, 8 data bits LSB first, stop; cut < 10 aborts early.
  task automatic send(input logic [7:0] b, input bit stop_ok,
                      input int cut = 10);
    logic [9:0] bits;
    bits = {stop_ok, b, 1'b0};
    if (cut >= 10)
      expq.push_back('{err: !stop_ok, at: cyc + LAT, data: b});
    for (int i = 0; i < 10; i++) begin
      if (i == cut) return;
      rxd = bits[i];
      repeat (BD) step();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"}, 32'(rx_data), 32'd0);
    check({tag, "_done"}, 32'(rx_done), 32'd0);
    check({tag, "_err"}, 32'(rx_ferr), 32'd0);
    check({tag, "_busy"}, 32'(rx_busy), 32'd0);
  endtask

  int         busy_cnt;
  logic [7:0] bb;
  logic [9:0] bits_b;
  int         t0;
  int         got_cyc;
  logic [7:0] got_data;
  bit         saw_ferr_b;
  bit         ok;

  initial begin
    step();
    repeat (3) begin
      @(negedge clk);
      check_reset_outputs("rst");
      check("rst_b_busy", 32'(busy_b), 32'd0);
      check("rst_b_data", 32'(rx_data_b), 32'd0);
      #1;
    end
    rst_n = 1'b1;
    idle(20);

    // Single frame after idle
    send(8'h55, 1'b1);
    idle(20);
    check("t1_pending", expq.size(), 32'd0);

    // Back-to-back frames, zero idle
    send(8'hA5, 1'b1);
    send(8'h3C, 1'b1);
    idle(20);
    check("t2_pending", expq.size(), 32'd0);

    // Start-bit glitch of 3 cycles
    busy_cnt = 0;
    rxd = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      busy_cnt += int'(rx_busy);
      #1;
      if (i == 2) rxd = 1'b1;
    end
    check("t3_busy_len", busy_cnt, HF);

    // Framing error, then a break held low, then a good frame
    send(8'h00, 1'b0);
    rxd = 1'b0;
    repeat (50) step();
    idle(BD);
    send(8'h12, 1'b1);
    idle(20);
    check("t4_pending", expq.size(), 32'd0);

    // Reset during data bit 4 of 0xF0
    send(8'hF0, 1'b1, 5);
    rxd = 1'b1;
    repeat (3) step();
    rst_n = 1'b0;
    expq.delete();
    last_good = 8'd0;
    repeat (2) begin
      @(negedge clk);
      check_reset_outputs("t5_rst");
      #1;
    end
    rst_n = 1'b1;
    idle(20);
    send(8'h81, 1'b1);
    idle(20);
    check("t5_pending", expq.size(), 32'd0);

    // Line held low across reset release
    rst_n = 1'b0;
    rxd = 1'b0;
    last_good = 8'd0;
    repeat (5) step();
    rst_n = 1'b1;
    repeat (30) step();
    idle(20);
    check("t6_data_before", 32'(rx_data), 32'd0);
    send(8'h7E, 1'b1);
    idle(20);
    check("t6_pending", expq.size(), 32'd0);

    // Random burst with random gaps and occasional bad stop bits
    for (int f = 0; f < 12; f++) begin
      bb = 8'($urandom);
      ok = ($urandom_range(0, 5) != 0);
      send(bb, ok);
      idle(ok ? int'($urandom_range(0, 12)) : int'($urandom_range(2, 12)));
    end
    idle(20);
    check("rand_pending", expq.size(), 32'd0);

    // One frame at the default divider
    bb = 8'($urandom);
    bits_b = {1'b1, bb, 1'b0};
    t0 = cyc;
    got_cyc = -1;
    got_data = 8'd0;
    saw_ferr_b = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          rxd_b = bits_b[i];
          repeat (BD_B) step();
        end
        rxd_b = 1'b1;
      end
      begin
        for (int k = 0; k < 12 * BD_B && got_cyc < 0; k++) begin
          @(negedge clk);
          if (ferr_b) saw_ferr_b = 1'b1;
          if (done_b) begin
            got_cyc = cyc;
            got_data = rx_data_b;
          end
        end
      end
    join
    check("b_seen", 32'(got_cyc >= 0), 32'd1);
    check("b_cycle", got_cyc, t0 + LAT_B);
    check("b_data", 32'(got_data), 32'(bb));
    check("b_no_err", 32'(saw_ferr_b), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
